// File: rtl/stream_fifo.sv
// ----------------------------------------------------------------------------
// stream_fifo
//   Multi-entry valid/ready FIFO placed between a producer and a single-entry
//   pipe register downstream (e.g. fetch -> instruction queue -> decode).
//   Absorbs bursts of up to DEPTH items, supports a synchronous flush for
//   mispredict/exception recovery, and reports its occupancy.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. The offering side holds valid/data stable until the
//   transfer. ready_in never depends on ready_out, and valid_out/data_out
//   come from registered state only.
//
// Parameters
//   data_t     payload type carried per entry
//   DEPTH      number of entries, power of two, >= 2
//
// Ports
//   clk        clock, all state updates on posedge
//   resetn     synchronous reset, active-low
//   flush      synchronous discard of all entries
//   ready_in   FIFO can accept data_in this cycle
//   valid_in   producer offers data_in
//   data_in    payload to enqueue
//   ready_out  consumer takes data_out this cycle
//   valid_out  data_out holds the oldest entry
//   data_out   oldest entry, '0 when valid_out is low
//   count      number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module stream_fifo #(
    parameter type data_t = logic,
    parameter int  DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    output logic                     ready_in,
    input  logic                     valid_in,
    input  data_t                    data_in,
    input  logic                     ready_out,
    output logic                     valid_out,
    output data_t                    data_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so that full and empty are distinct
    // even though both have equal index bits.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    data_t         mem_q [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

    // A full FIFO refuses input even when it pops the same cycle; this keeps
    // ready_in free of any path from ready_out.
    assign ready_in  = resetn && !flush && !full;
    assign valid_out = !empty;
    assign data_out  = empty ? '0 : mem_q[head_q[AW-1:0]];
    assign count     = tail_q - head_q;

    assign push = valid_in && ready_in;
    assign pop  = valid_out && ready_out;

    // Reset beats flush beats push/pop. A pop handshake during flush is
    // simply dropped along with everything else.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!resetn || flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    // Storage is not reset; the pointers alone define what is valid. push
    // is already gated by resetn and flush through ready_in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// ----------------------------------------------------------------------------
// tb_stream_fifo
//   Bench for stream_fifo with 8-bit payload and DEPTH=4. The reference model
//   is a plain queue of stored items (exp_q): its size is the occupancy and
//   its front is the oldest entry.
// ----------------------------------------------------------------------------
module tb_stream_fifo;

    localparam int DEPTH = 4;
    typedef logic [7:0] byte_t;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn    = 1'b0;
    logic       flush     = 1'b0;
    logic       valid_in  = 1'b0;
    byte_t      data_in   = '0;
    logic       ready_out = 1'b0;
    logic       ready_in;
    logic       valid_out;
    byte_t      data_out;
    logic [2:0] count;

    stream_fifo #(
        .data_t (byte_t),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .ready_in  (ready_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .count     (count)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         occ_before  = 0;
    bit         checking    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the active edge, from the inputs that were stable
    // through the preceding cycle. occ_before is the occupancy seen before
    // any pop this cycle, so a full FIFO refuses input even while popping.
    always @(posedge clk) begin
        if (!resetn || flush) begin
            exp_q.delete();
        end else if (valid_in && occ_before < DEPTH) begin
            exp_q.push_back(data_in);
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires the oldest item
    // whenever the consumer takes it.
    always @(negedge clk) begin
        occ_before = exp_q.size();
        if (checking) begin
            check("count", 32'(count), 32'(occ_before));
            check("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
            check("valid_out", 32'(valid_out), 32'(occ_before > 0));
            check("ready_in", 32'(ready_in), 32'(resetn && !flush && occ_before < DEPTH));
            if (occ_before > 0) begin
                check("data_out", 32'(data_out), 32'(exp_q[0]));
                if (resetn && !flush && ready_out) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                check("data_out_idle", 32'(data_out), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst_n, input logic fl, input logic vi,
                         input byte_t d, input logic ro);
        resetn    = rst_n;
        flush     = fl;
        valid_in  = vi;
        data_in   = d;
        ready_out = ro;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    byte_t burst[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        do_reset();
        checking = 1'b1;

        // Reset then idle.
        idle(3);

        // Fill to DEPTH with consumer stalled; fifth offer must be refused.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, burst[i], 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
        // Drain in order.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Full FIFO with simultaneous offer and take: only the pop happens,
        // then the offer is accepted on the following cycle.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'hB5, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'hB5, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Continuous stream 0..19: occupancy settles at 1, pointers wrap.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Three stored, then flush with both handshakes offered.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hCF, 1'b1);
        idle(2);
        // First push after flush.
        drive(1'b1, 1'b0, 1'b1, 8'hD1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);

        // Mid-stream reset with data stored.
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 8'hE0 + 8'(i), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        idle(2);

        // Random traffic with occasional reset pulses and flushes.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 199) != 0),
                  1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
